// File: rtl/cache_pkg.sv
// Shared dcache types: MESI encoding, data word and flush sequencer states.
package cache_pkg;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10,
    MODIFIED  = 2'b11
  } mesi_t;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WB,
    INV,
    COUNTER,
    DONE
  } dflush_state_t;

endpackage

// File: rtl/flush_index_counter.sv
// Nested set/way/word walker for the dcache flush sequencer.
module flush_index_counter #(
  parameter  int SETS  = 8,
  parameter  int WAYS  = 2,
  parameter  int WORDS = 2,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int WRD_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             inc_word,
  input  logic             inc_blk,
  output logic [SET_W-1:0] set_o,
  output logic [WAY_W-1:0] way_o,
  output logic [WRD_W-1:0] word_o,
  output logic             last_word,
  output logic             last_blk
);

  typedef struct packed {
    logic [SET_W-1:0] set;
    logic [WAY_W-1:0] way;
    logic [WRD_W-1:0] word;
  } flush_cnt_t;

  flush_cnt_t cnt_q, cnt_d;
  logic       last_way;
  logic       last_set;

  assign last_word = cnt_q.word == WRD_W'(WORDS - 1);
  assign last_way  = cnt_q.way == WAY_W'(WAYS - 1);
  assign last_set  = cnt_q.set == SET_W'(SETS - 1);
  assign last_blk  = last_way && last_set;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc_blk) begin
      // way is the inner loop, set the outer one
      cnt_d.word = '0;
      cnt_d.way  = last_way ? '0 : cnt_q.way + 1'b1;
      if (last_way)
        cnt_d.set = last_set ? '0 : cnt_q.set + 1'b1;
    end else if (inc_word) begin
      cnt_d.word = last_word ? '0 : cnt_q.word + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign set_o  = cnt_q.set;
  assign way_o  = cnt_q.way;
  assign word_o = cnt_q.word;

endmodule

// File: rtl/dcache_flush_engine.sv
// Halt-time dcache flush: write back MODIFIED blocks, invalidate all, store hit count.
module dcache_flush_engine
  import cache_pkg::*;
#(
  parameter  int          SETS     = 8,
  parameter  int          WAYS     = 2,
  parameter  int          WORDS    = 2,
  parameter  logic [31:0] CNT_ADDR = 32'h3100,
  localparam int          SET_W    = $clog2(SETS),
  localparam int          WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int          WRD_W    = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int          OFF_W    = $clog2(WORDS),
  localparam int          TAG_W    = 32 - SET_W - OFF_W - 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               halt,
  input  logic [31:0]        hit_count,
  output logic [SET_W-1:0]   rd_set,
  output logic [WAY_W-1:0]   rd_way,
  input  mesi_t              blk_mesi,
  input  logic [TAG_W-1:0]   blk_tag,
  input  logic [WORDS*32-1:0] blk_data,
  output logic               inv_en,
  output logic               mem_wen,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_store,
  input  logic               mem_wait,
  output logic               busy,
  output logic               flush_done
);

  dflush_state_t    state_q, state_d;
  logic             wen_q, wen_d;
  word_t            addr_q, addr_d;
  word_t            store_q, store_d;
  logic             inv_q, inv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clr, inc_word, inc_blk;
  logic             last_word, last_blk;
  logic [WRD_W-1:0] word;

  flush_index_counter #(
    .SETS (SETS),
    .WAYS (WAYS),
    .WORDS(WORDS)
  ) u_idx (
    .CLK      (CLK),
    .nRST     (nRST),
    .clr      (clr),
    .inc_word (inc_word),
    .inc_blk  (inc_blk),
    .set_o    (rd_set),
    .way_o    (rd_way),
    .word_o   (word),
    .last_word(last_word),
    .last_blk (last_blk)
  );

  function automatic word_t blk_addr(
    input logic [TAG_W-1:0] tag,
    input logic [SET_W-1:0] set,
    input logic [WRD_W-1:0] w
  );
    return (word_t'(tag) << (32 - TAG_W))
         | (word_t'(set) << (OFF_W + 2))
         | (word_t'(w) << 2);
  endfunction

  function automatic word_t blk_word(
    input logic [WORDS*32-1:0] data,
    input logic [WRD_W-1:0]    w
  );
    return word_t'(data >> {w, 5'd0});
  endfunction

  // memory outputs are registered one state ahead so they hold through waits
  always_comb begin
    state_d  = state_q;
    wen_d    = 1'b0;
    addr_d   = addr_q;
    store_d  = store_q;
    inv_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    clr      = 1'b0;
    inc_word = 1'b0;
    inc_blk  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = CHECK;
          busy_d  = 1'b1;
          clr     = 1'b1;
        end
      end
      CHECK: begin
        if (blk_mesi == MODIFIED) begin
          state_d = WB;
          wen_d   = 1'b1;
          addr_d  = blk_addr(blk_tag, rd_set, word);
          store_d = blk_word(blk_data, word);
        end else begin
          state_d = INV;
          inv_d   = 1'b1;
        end
      end
      WB: begin
        wen_d = 1'b1;
        if (!mem_wait) begin
          if (last_word) begin
            state_d = INV;
            wen_d   = 1'b0;
            inv_d   = 1'b1;
          end else begin
            inc_word = 1'b1;
            addr_d   = blk_addr(blk_tag, rd_set, word + 1'b1);
            store_d  = blk_word(blk_data, word + 1'b1);
          end
        end
      end
      INV: begin
        inc_blk = 1'b1;
        if (last_blk) begin
          state_d = COUNTER;
          wen_d   = 1'b1;
          addr_d  = CNT_ADDR;
          store_d = hit_count;
        end else begin
          state_d = CHECK;
        end
      end
      COUNTER: begin
        wen_d = 1'b1;
        if (!mem_wait) begin
          state_d = DONE;
          wen_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_wen    = wen_q;
  assign mem_addr   = addr_q;
  assign mem_store  = store_q;
  assign inv_en     = inv_q;
  assign busy       = busy_q;
  assign flush_done = done_q;

endmodule
